// File: rtl/hs_sync_pkg.sv
// Shared types and constants for the 4-phase sync sink.
// Build option: HS4_SINK_SYNC3_EN selects a 3-flop request synchroniser (2 flops otherwise).
package hs_sync_pkg;

  typedef enum logic {HS_IDLE, HS_ACKED} hs_state_e;

`ifdef HS4_SINK_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_chain;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], d_i};
  end

  assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/hs4_sync_sink.sv
// Clocked sink for one branch of a 4-phase bundled-data fork.
// Synchronises req_i, captures data_i into a FIFO, returns a 4-phase ack,
// and presents words on a valid/ready interface.
// Build option: HS4_SINK_SYNC3_EN (via hs_sync_pkg) lengthens the synchroniser to 3 flops.
module hs4_sync_sink
  import hs_sync_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ack_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              w_req_s;
  hs_state_e         r_state;
  hs_state_e         w_state_nxt;
  logic              r_ack;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (req_i),
    .q_o   (w_req_s)
  );

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign valid_o = (r_count != '0);
  assign w_pop   = valid_o & ready_i;
  assign w_push  = (r_state == HS_IDLE) & w_req_s & ~w_full;

  // Handshake next state: capture once per request, release ack when req_s drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HS_IDLE:  if (w_push)   w_state_nxt = HS_ACKED;
      HS_ACKED: if (!w_req_s) w_state_nxt = HS_IDLE;
      default:                w_state_nxt = HS_IDLE;
    endcase
  end

  // State and ack registers; ack comes straight from a flop to keep it glitch-free upstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= HS_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == HS_ACKED);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; data_i is stable on the capture edge by the bundled-data contract.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign ack_o   = r_ack;
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: tb/tb_hs4_sync_sink.sv
// Directed self-checking bench for hs4_sync_sink (DATA_W=32, DEPTH=4).
module tb_hs4_sync_sink;

`ifdef HS4_SINK_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] data_i;
  logic        ack_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [2:0]  count_o;

  int n_chk = 0;
  int n_err = 0;

  // stream monitor
  bit          mon_en = 1'b0;
  logic [31:0] mon_q [$];
  int          mon_max_cnt = 0;

  hs4_sync_sink #(.DATA_W(32), .DEPTH(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mon_en) begin
      if (valid_o && ready_i) mon_q.push_back(data_o);
      if (int'(count_o) > mon_max_cnt) mon_max_cnt = int'(count_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Full 4-phase cycle with bounded waits; ok=0 if either phase timed out.
  task automatic hs(input logic [31:0] d, output bit ok);
    bit up;
    data_i = d;
    req_i  = 1'b1;
    up = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ack_o) begin up = 1'b1; break; end
    end
    req_i = 1'b0;
    ok = 1'b0;
    if (up) begin
      for (int i = 0; i < 40; i++) begin
        tick(1);
        if (!ack_o) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; ready_i = 1'b0; data_i = '0;
    tick(2);
    n_chk++; if (ack_o !== 1'b0)   begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    n_chk++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_chk++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    rst_i = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    data_i = 32'hDEADBEEF;
    req_i  = 1'b1;
    tick(LAT-1);
    n_chk++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL single_ack_early got=%b exp=0", ack_o); end
    tick(1);
    n_chk++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL single_ack_rise got=%b exp=1", ack_o); end
    tick(1);
    n_chk++; if (valid_o !== 1'b1 || data_o !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL single_data got=%b/%h exp=1/deadbeef", valid_o, data_o); end
    req_i = 1'b0;
    tick(LAT-1);
    n_chk++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL single_ack_hold got=%b exp=1", ack_o); end
    tick(1);
    n_chk++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL single_ack_fall got=%b exp=0", ack_o); end
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    n_chk++; if (count_o !== 3'd0 || valid_o !== 1'b0)
      begin n_err++; $display("FAIL single_drain got=%0d/%b exp=0/0", count_o, valid_o); end
  endtask

  task automatic test_fill();
    bit ok;
    ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      hs(32'(k), ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL fill_hs%0d timeout got=0 exp=1", k); end
    end
    n_chk++; if (count_o !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", count_o); end
    data_i = 32'd5;
    req_i  = 1'b1;
    tick(10);
    n_chk++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL fill_held_ack got=%b exp=0", ack_o); end
    n_chk++; if (data_o !== 32'd1) begin n_err++; $display("FAIL fill_head got=%h exp=1", data_o); end
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    n_chk++; if (count_o !== 3'd3 || ack_o !== 1'b0)
      begin n_err++; $display("FAIL fill_after_pop got=%0d/%b exp=3/0", count_o, ack_o); end
    tick(1);
    n_chk++; if (count_o !== 3'd4 || ack_o !== 1'b1)
      begin n_err++; $display("FAIL fill_word5 got=%0d/%b exp=4/1", count_o, ack_o); end
    req_i = 1'b0;
    tick(LAT);
    n_chk++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL fill_ack_fall got=%b exp=0", ack_o); end
    ready_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_chk++; if (data_o !== 32'(k) || valid_o !== 1'b1)
        begin n_err++; $display("FAIL fill_drain%0d got=%b/%h exp=1/%h", k, valid_o, data_o, k); end
      tick(1);
    end
    ready_i = 1'b0;
    n_chk++; if (count_o !== 3'd0) begin n_err++; $display("FAIL fill_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_stream();
    bit ok;
    mon_q.delete();
    mon_max_cnt = 0;
    ready_i = 1'b1;
    mon_en  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      hs(32'h0000_00A0 + 32'(k), ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL stream_hs%0d timeout got=0 exp=1", k); end
    end
    tick(3);
    mon_en  = 1'b0;
    ready_i = 1'b0;
    n_chk++; if (mon_q.size() != 8) begin n_err++; $display("FAIL stream_count got=%0d exp=8", mon_q.size()); end
    for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
      n_chk++; if (mon_q[k] !== 32'h0000_00A0 + 32'(k))
        begin n_err++; $display("FAIL stream_word%0d got=%h exp=%h", k, mon_q[k], 32'h0000_00A0 + 32'(k)); end
    end
    n_chk++; if (mon_max_cnt > 1) begin n_err++; $display("FAIL stream_maxcount got=%0d exp<=1", mon_max_cnt); end
  endtask

  task automatic test_simul();
    bit ok;
    ready_i = 1'b0;
    hs(32'h11, ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL simul_hs1 timeout got=0 exp=1"); end
    hs(32'h22, ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL simul_hs2 timeout got=0 exp=1"); end
    n_chk++; if (count_o !== 3'd2) begin n_err++; $display("FAIL simul_pre_count got=%0d exp=2", count_o); end
    data_i = 32'h33;
    req_i  = 1'b1;
    tick(LAT-1);
    ready_i = 1'b1;
    n_chk++; if (data_o !== 32'h11) begin n_err++; $display("FAIL simul_head got=%h exp=11", data_o); end
    tick(1);
    ready_i = 1'b0;
    n_chk++; if (count_o !== 3'd2 || ack_o !== 1'b1)
      begin n_err++; $display("FAIL simul_count got=%0d/%b exp=2/1", count_o, ack_o); end
    req_i = 1'b0;
    tick(LAT);
    ready_i = 1'b1;
    n_chk++; if (data_o !== 32'h22) begin n_err++; $display("FAIL simul_order1 got=%h exp=22", data_o); end
    tick(1);
    n_chk++; if (data_o !== 32'h33) begin n_err++; $display("FAIL simul_order2 got=%h exp=33", data_o); end
    tick(1);
    ready_i = 1'b0;
    n_chk++; if (count_o !== 3'd0) begin n_err++; $display("FAIL simul_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_rst_mid();
    bit up;
    ready_i = 1'b0;
    data_i  = 32'h55;
    req_i   = 1'b1;
    up = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ack_o) begin up = 1'b1; break; end
    end
    n_chk++; if (!up) begin n_err++; $display("FAIL rstmid_ack timeout got=0 exp=1"); end
    #2 rst_i = 1'b1;
    #1;
    n_chk++; if (ack_o !== 1'b0 || count_o !== 3'd0 || valid_o !== 1'b0)
      begin n_err++; $display("FAIL rstmid_clear got=%b/%0d/%b exp=0/0/0", ack_o, count_o, valid_o); end
    tick(1);
    rst_i = 1'b0;
    tick(LAT + 2);
    n_chk++; if (count_o !== 3'd1 || ack_o !== 1'b1 || data_o !== 32'h55)
      begin n_err++; $display("FAIL rstmid_recapture got=%0d/%b/%h exp=1/1/55", count_o, ack_o, data_o); end
    req_i = 1'b0;
    tick(LAT + 1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_simul();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
